// File: rtl/sync_f2s_s_pkg.sv
// sync_f2s_s_pkg: shared definitions for the fast->slow hold-signal handshake
// synchronizer (slow-domain half).
//   state_e          registered FSM state encodings S_IDLE, S_VALID, S_ACK
//   SYNC_STAGES_MIN  smallest legal synchronizer depth
package sync_f2s_s_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VALID = 2'd1,
        S_ACK   = 2'd2
    } state_e;

    localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_nff.sv
// sync_nff: generic STAGES-deep single-bit synchronizer, synchronous active-high reset.
//   i_clk  in   destination clock
//   i_rst  in   synchronous active-high reset, clears the whole chain
//   i_d    in   asynchronous input bit
//   o_q    out  synchronized bit (last flop of the chain)
module sync_nff #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sync_f2s_s.sv
// sync_f2s_s: slow-clock half of the fast->slow 4-phase hold-signal synchronizer.
// Synchronizes the held request rd_en_i, offers it once as a valid/ready transfer and
// returns a registered acknowledge that the fast half uses to release its request.
//   clk_s        in   slow domain clock
//   rst          in   synchronous active-high reset
//   rd_en_i      in   request from fast domain, asynchronous, held until acked
//   rd_en_ack_o  out  acknowledge to fast domain (registered state decode)
//   rd_vld_o     out  request valid toward slow consumer (registered state decode)
//   rd_rdy_i     in   consumer ready; transfer when rd_vld_o & rd_rdy_i
//   err_o        out  sticky flag: request dropped while still valid
//   rd_cnt_o     out  completed-transfer count
// Optional feature macro SYNC_F2S_S_CNT_EN: enables the wrapping transfer counter;
// when undefined rd_cnt_o is constant 0.
module sync_f2s_s
    import sync_f2s_s_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk_s,
    input  logic             rst,
    input  logic             rd_en_i,
    output logic             rd_en_ack_o,
    output logic             rd_vld_o,
    input  logic             rd_rdy_i,
    output logic             err_o,
    output logic [CNT_W-1:0] rd_cnt_o
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $fatal(1, "sync_f2s_s: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
    end

    logic   w_req_s;
    state_e r_state;
    state_e w_state_nxt;
    logic   r_err;
    logic   w_err_nxt;

    sync_nff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_req (
        .i_clk (clk_s),
        .i_rst (rst),
        .i_d   (rd_en_i),
        .o_q   (w_req_s)
    );

    always_ff @(posedge clk_s) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_req_s) begin
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                // Fast side released early; keep offering so the transfer still completes.
                if (!w_req_s) begin
                    w_err_nxt = 1'b1;
                end
                if (rd_rdy_i) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                // Only a seen low level re-arms, so a held request is never re-delivered.
                if (!w_req_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_vld_o    = (r_state == S_VALID);
    assign rd_en_ack_o = (r_state == S_ACK);
    assign err_o       = r_err;

`ifdef SYNC_F2S_S_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_s) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (rd_vld_o && rd_rdy_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign rd_cnt_o = r_cnt;
`else
    assign rd_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sync_f2s_s.sv
// tb_sync_f2s_s: self-checking bench for sync_f2s_s (SYNC_STAGES=2, CNT_W=4).
// Inputs are driven on the falling edge; outputs are sampled on the next falling edge.
module tb_sync_f2s_s;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = 4;

    logic             clk_s = 1'b0;
    logic             rst;
    logic             rd_en_i;
    logic             rd_rdy_i;
    logic             rd_en_ack_o;
    logic             rd_vld_o;
    logic             err_o;
    logic [CNT_W-1:0] rd_cnt_o;

    always #5 clk_s = ~clk_s;

    sync_f2s_s #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_s       (clk_s),
        .rst         (rst),
        .rd_en_i     (rd_en_i),
        .rd_en_ack_o (rd_en_ack_o),
        .rd_vld_o    (rd_vld_o),
        .rd_rdy_i    (rd_rdy_i),
        .err_o       (err_o),
        .rd_cnt_o    (rd_cnt_o)
    );

    typedef struct {
        logic rst;
        logic en;
        logic rdy;
        logic vld;
        logic ack;
        logic err;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        sb_q[$];
    vec_t        vecs[10];
    logic        last_vld;
    int unsigned exp_cnt;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] act,
                             input logic [CNT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt_now();
`ifdef SYNC_F2S_S_CNT_EN
        return CNT_W'(exp_cnt);
`else
        return '0;
`endif
    endfunction

    // One clock: drive inputs, queue expected outputs, sample after the edge and compare.
    task automatic step(input logic r, input logic en, input logic rdy, input logic vld,
                        input logic ack, input logic err, input string tag);
        vec_t v;
        v = '{r, en, rdy, vld, ack, err};
        rst      = r;
        rd_en_i  = en;
        rd_rdy_i = rdy;
        if (r) begin
            exp_cnt = 0;
        end else if (last_vld && rdy) begin
            exp_cnt++;
        end
        sb_q.push_back(v);
        @(posedge clk_s);
        @(negedge clk_s);
        v = sb_q.pop_front();
        check_bit($sformatf("%s.vld", tag), rd_vld_o, v.vld);
        check_bit($sformatf("%s.ack", tag), rd_en_ack_o, v.ack);
        check_bit($sformatf("%s.err", tag), err_o, v.err);
        check_cnt($sformatf("%s.cnt", tag), rd_cnt_o, exp_cnt_now());
        last_vld = v.vld;
    endtask

    // Complete handshake with a ready consumer and a timely release.
    task automatic handshake(input string tag);
        step(0, 1, 1, 0, 0, 0, {tag, ".s1"});
        step(0, 1, 1, 0, 0, 0, {tag, ".s2"});
        step(0, 1, 1, 1, 0, 0, {tag, ".vld"});
        step(0, 1, 1, 0, 1, 0, {tag, ".ack"});
        step(0, 0, 1, 0, 1, 0, {tag, ".rel1"});
        step(0, 0, 1, 0, 1, 0, {tag, ".rel2"});
        step(0, 0, 1, 0, 0, 0, {tag, ".idle"});
    endtask

    initial begin
        //          rst en rdy vld ack err
        vecs[0] = '{1, 0, 0, 0, 0, 0};  // reset
        vecs[1] = '{1, 1, 1, 0, 0, 0};  // request held off by reset
        vecs[2] = '{0, 1, 1, 0, 0, 0};  // edge 1: first sample of 1
        vecs[3] = '{0, 1, 1, 0, 0, 0};  // edge 2: req_s rises
        vecs[4] = '{0, 1, 1, 1, 0, 0};  // edge 3: valid
        vecs[5] = '{0, 1, 1, 0, 1, 0};  // edge 4: transfer done, ack
        vecs[6] = '{0, 0, 1, 0, 1, 0};  // first sample of 0
        vecs[7] = '{0, 0, 1, 0, 1, 0};
        vecs[8] = '{0, 0, 1, 0, 0, 0};  // ack drops 3 edges after release
        vecs[9] = '{0, 0, 1, 0, 0, 0};

        rst      = 1'b1;
        rd_en_i  = 1'b0;
        rd_rdy_i = 1'b0;
        last_vld = 1'b0;
        exp_cnt  = 0;
        @(negedge clk_s);

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].rdy, vecs[i].vld, vecs[i].ack, vecs[i].err,
                 $sformatf("basic[%0d]", i));
        end

        // Backpressure: valid waits for ready without acking.
        step(0, 1, 0, 0, 0, 0, "bp.s1");
        step(0, 1, 0, 0, 0, 0, "bp.s2");
        step(0, 1, 0, 1, 0, 0, "bp.vld");
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 1, 0, 0, $sformatf("bp.wait[%0d]", i));
        end
        step(0, 1, 1, 0, 1, 0, "bp.ack");
        step(0, 0, 0, 0, 1, 0, "bp.rel1");
        step(0, 0, 0, 0, 1, 0, "bp.rel2");
        step(0, 0, 0, 0, 0, 0, "bp.idle");

        // Held request: single delivery, ack held until release.
        step(0, 1, 1, 0, 0, 0, "hold.s1");
        step(0, 1, 1, 0, 0, 0, "hold.s2");
        step(0, 1, 1, 1, 0, 0, "hold.vld");
        step(0, 1, 1, 0, 1, 0, "hold.ack");
        for (int i = 0; i < 50; i++) begin
            step(0, 1, 1, 0, 1, 0, $sformatf("hold.keep[%0d]", i));
        end
        step(0, 0, 1, 0, 1, 0, "hold.rel1");
        step(0, 0, 1, 0, 1, 0, "hold.rel2");
        step(0, 0, 1, 0, 0, 0, "hold.idle");

        // Protocol error: request dropped while valid; err sticky, transfer completes.
        step(0, 1, 0, 0, 0, 0, "err.s1");
        step(0, 1, 0, 0, 0, 0, "err.s2");
        step(0, 1, 0, 1, 0, 0, "err.vld");
        step(0, 0, 0, 1, 0, 0, "err.drop1");
        step(0, 0, 0, 1, 0, 0, "err.drop2");
        step(0, 0, 0, 1, 0, 1, "err.flag");
        step(0, 0, 1, 0, 1, 1, "err.xfer");
        step(0, 0, 0, 0, 0, 1, "err.idle");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 1, $sformatf("err.sticky[%0d]", i));
        end

        // Reset while valid with request still held; request re-delivered afterwards.
        step(0, 1, 0, 0, 0, 1, "rst.s1");
        step(0, 1, 0, 0, 0, 1, "rst.s2");
        step(0, 1, 0, 1, 0, 1, "rst.vld");
        step(1, 1, 0, 0, 0, 0, "rst.reset");
        step(0, 1, 1, 0, 0, 0, "rst.re1");
        step(0, 1, 1, 0, 0, 0, "rst.re2");
        step(0, 1, 1, 1, 0, 0, "rst.re_vld");
        step(0, 1, 1, 0, 1, 0, "rst.re_ack");
        step(0, 0, 1, 0, 1, 0, "rst.rel1");
        step(0, 0, 1, 0, 1, 0, "rst.rel2");
        step(0, 0, 1, 0, 0, 0, "rst.idle");

        // 17 handshakes from reset: counter wraps to 1 with CNT_W=4.
        step(1, 0, 0, 0, 0, 0, "wrap.reset");
        for (int i = 0; i < 17; i++) begin
            handshake($sformatf("wrap[%0d]", i));
        end
`ifdef SYNC_F2S_S_CNT_EN
        check_cnt("wrap.final", rd_cnt_o, 4'd1);
`else
        check_cnt("wrap.final", rd_cnt_o, 4'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
